// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO write-side bundle for fifo_wr_arbiter.
// slave = the arbiter; master = whatever drives the producers and models the FIFO.
interface fifo_wr_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  fifo_full;
  logic                  fifo_wr;
  logic [WIDTH-1:0]      fifo_wdata;

  modport slave (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_wr, fifo_wdata
  );

  modport master (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_wr, fifo_wdata
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-limited arbiter sharing one FIFO write port between NREQ producers.
// Define FIFO_ARB_PRIO_EN to make requester 0 win every arbitration it is valid for.
module fifo_wr_arbiter #(
  parameter  int WIDTH     = 8,
  parameter  int NREQ      = 4,
  parameter  int MAX_BURST = 4,
  localparam int IDW       = ($clog2(NREQ) > 1) ? $clog2(NREQ) : 1,
  localparam int CW        = ($clog2(MAX_BURST) > 1) ? $clog2(MAX_BURST) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  fifo_wr_arbiter_if.slave        bus,
  output logic [IDW-1:0]          gnt_id,
  output logic                    busy
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  gnt_q, gnt_d;
  logic [IDW-1:0]  rr_q, rr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            xfer;
  logic            release_g;
  logic [IDW:0]    arb;
  logic [WIDTH-1:0] word [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign word[i] = bus.req_data[i*WIDTH +: WIDTH];
  end

  // Returns {found, winner}; the search starts after `last` and visits `last` itself last.
  function automatic logic [IDW:0] pick(input logic [NREQ-1:0] valid,
                                        input logic [IDW-1:0]  last);
    logic            found;
    logic [IDW-1:0]  win;
    int unsigned     idx;
    found = 1'b0;
    win   = '0;
    for (int unsigned k = 1; k <= int'(NREQ); k++) begin
      idx = (32'(last) + k) % int'(NREQ);
      if (!found && valid[IDW'(idx)]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
`ifdef FIFO_ARB_PRIO_EN
    if (valid[0]) begin
      found = 1'b1;
      win   = '0;
    end
`endif
    return {found, win};
  endfunction

  assign xfer = (state_q == BURST) && bus.req_valid[gnt_q] && !bus.fifo_full;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      cnt_q   <= '0;
      rr_q    <= IDW'(NREQ - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    cnt_d     = cnt_q;
    rr_d      = rr_q;
    arb       = '0;
    release_g = 1'b0;
    unique case (state_q)
      IDLE: begin
        arb = pick(bus.req_valid, rr_q);
        if (arb[IDW]) begin
          state_d = BURST;
          gnt_d   = arb[IDW-1:0];
          cnt_d   = '0;
        end
      end
      BURST: begin
        // Full alone never releases; only burst completion or a dropped valid does.
        release_g = (xfer && (cnt_q == CW'(MAX_BURST - 1))) || !bus.req_valid[gnt_q];
        if (release_g) begin
          rr_d = gnt_q;
          arb  = pick(bus.req_valid, gnt_q);
          if (arb[IDW]) begin
            gnt_d = arb[IDW-1:0];
            cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (xfer) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = '0;
    bus.fifo_wr    = 1'b0;
    bus.fifo_wdata = '0;
    busy           = (state_q == BURST);
    gnt_id         = gnt_q;
    if (state_q == BURST) begin
      bus.req_ready[gnt_q] = !bus.fifo_full;
      bus.fifo_wr          = xfer;
      bus.fifo_wdata       = word[gnt_q];
    end
  end

  a_ready_onehot0: assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0(bus.req_ready));
  a_wr_is_handshake: assert property (@(posedge clk) disable iff (!reset_n)
    bus.fifo_wr == |(bus.req_valid & bus.req_ready));
  a_no_wr_when_full: assert property (@(posedge clk) disable iff (!reset_n)
    bus.fifo_full |-> !bus.fifo_wr);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: vector table, directed corner sequences, then random traffic
// against a cycle-level reference model.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;
  localparam int WIDTH     = 8;
  localparam int NREQ      = 4;
  localparam int MAX_BURST = 4;
  localparam int IDW       = 2;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [IDW-1:0] gnt_id;
  logic           busy;

  int checks = 0;
  int errors = 0;

  fifo_wr_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

  fifo_wr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .MAX_BURST(MAX_BURST)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .gnt_id  (gnt_id),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit              m_busy;
  int              m_g, m_cnt, m_last;
  logic [NREQ-1:0] last_rdy;

  function automatic bit bit_of(input logic [NREQ-1:0] v, input int i);
    logic [IDW-1:0] k;
    k = i[IDW-1:0];
    return v[k];
  endfunction

  function automatic logic [WIDTH-1:0] data_of(input int i);
    return WIDTH'(bus.req_data >> (i * WIDTH));
  endfunction

  function automatic int m_pick(input logic [NREQ-1:0] v, input int last);
`ifdef FIFO_ARB_PRIO_EN
    if (v[0]) return 0;
`endif
    for (int k = 1; k <= NREQ; k++)
      if (bit_of(v, (last + k) % NREQ)) return (last + k) % NREQ;
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_g = 0; m_cnt = 0; m_last = NREQ - 1;
  endtask

  task automatic model_clock();
    int w;
    bit x;
    if (!reset_n) begin
      model_reset();
      return;
    end
    if (!m_busy) begin
      w = m_pick(bus.req_valid, m_last);
      if (w >= 0) begin m_busy = 1'b1; m_g = w; m_cnt = 0; end
    end else begin
      x = bit_of(bus.req_valid, m_g) && !bus.fifo_full;
      if (x) m_cnt++;
      if (m_cnt == MAX_BURST || !bit_of(bus.req_valid, m_g)) begin
        m_last = m_g;
        w = m_pick(bus.req_valid, m_g);
        if (w >= 0) begin m_g = w; m_cnt = 0; end
        else m_busy = 1'b0;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_model(input string tag);
    logic [NREQ-1:0]  e_rdy;
    logic             e_wr;
    logic [WIDTH-1:0] e_wd;
    e_rdy = '0; e_wr = 1'b0; e_wd = '0;
    if (m_busy) begin
      if (!bus.fifo_full) e_rdy = NREQ'(1) << m_g;
      e_wr = bit_of(bus.req_valid, m_g) && !bus.fifo_full;
      e_wd = data_of(m_g);
    end
    last_rdy = e_rdy;
    chk({tag, ".busy"},  32'(busy),           32'(m_busy));
    chk({tag, ".gnt"},   32'(gnt_id),         32'(m_g));
    chk({tag, ".ready"}, 32'(bus.req_ready),  32'(e_rdy));
    chk({tag, ".wr"},    32'(bus.fifo_wr),    32'(e_wr));
    chk({tag, ".wdata"}, 32'(bus.fifo_wdata), 32'(e_wd));
  endtask

  // Call 1ns after a negedge with inputs already driven.
  task automatic step(input string tag);
    compare_model(tag);
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.req_valid = '0; bus.req_data = '0; bus.fifo_full = 1'b0;
    model_reset();
    #1;
    chk("reset.busy",  32'(busy), 0);
    chk("reset.gnt",   32'(gnt_id), 0);
    chk("reset.ready", 32'(bus.req_ready), 0);
    chk("reset.wr",    32'(bus.fifo_wr), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic [NREQ-1:0]  valid;
    logic             full;
    logic [WIDTH-1:0] d2;
    int               e_gnt;
    logic             e_busy;
    logic [NREQ-1:0]  e_rdy;
    logic             e_wr;
    logic [WIDTH-1:0] e_wd;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int eg[9];
    int ew[9];
    int e;

    // ---- single requester 2 streaming 0xA0..0xA5 ----
    tbl[0] = '{4'b0100, 1'b0, 8'hA0, 0, 1'b0, 4'b0000, 1'b0, 8'h00};
    tbl[1] = '{4'b0100, 1'b0, 8'hA0, 2, 1'b1, 4'b0100, 1'b1, 8'hA0};
    tbl[2] = '{4'b0100, 1'b0, 8'hA1, 2, 1'b1, 4'b0100, 1'b1, 8'hA1};
    tbl[3] = '{4'b0100, 1'b0, 8'hA2, 2, 1'b1, 4'b0100, 1'b1, 8'hA2};
    tbl[4] = '{4'b0100, 1'b0, 8'hA3, 2, 1'b1, 4'b0100, 1'b1, 8'hA3};
    tbl[5] = '{4'b0100, 1'b0, 8'hA4, 2, 1'b1, 4'b0100, 1'b1, 8'hA4};
    tbl[6] = '{4'b0100, 1'b0, 8'hA5, 2, 1'b1, 4'b0100, 1'b1, 8'hA5};
    tbl[7] = '{4'b0000, 1'b0, 8'h00, 2, 1'b1, 4'b0100, 1'b0, 8'h00};
    tbl[8] = '{4'b0000, 1'b0, 8'h00, 2, 1'b0, 4'b0000, 1'b0, 8'h00};

    do_reset();
    for (int r = 0; r < 9; r++) begin
      bus.req_valid = tbl[r].valid;
      bus.req_data  = 32'(tbl[r].d2) << 16;
      bus.fifo_full = tbl[r].full;
      #1;
      chk($sformatf("tbl%0d.gnt", r),   32'(gnt_id),         32'(tbl[r].e_gnt));
      chk($sformatf("tbl%0d.busy", r),  32'(busy),           32'(tbl[r].e_busy));
      chk($sformatf("tbl%0d.ready", r), 32'(bus.req_ready),  32'(tbl[r].e_rdy));
      chk($sformatf("tbl%0d.wr", r),    32'(bus.fifo_wr),    32'(tbl[r].e_wr));
      chk($sformatf("tbl%0d.wdata", r), 32'(bus.fifo_wdata), 32'(tbl[r].e_wd));
      @(posedge clk);
      model_clock();
      @(negedge clk);
    end

    // ---- round-robin fairness, all four valid ----
    do_reset();
    bus.req_valid = 4'b1111;
    bus.req_data  = 32'h33221100;
    for (int c = 0; c < 21; c++) begin
      #1;
`ifdef FIFO_ARB_PRIO_EN
      e = 0;
`else
      e = (c == 0) ? 0 : ((c - 1) / 4) % 4;
`endif
      chk($sformatf("rr%0d.gnt", c), 32'(gnt_id), 32'(e));
      chk($sformatf("rr%0d.wr", c),  32'(bus.fifo_wr), (c == 0) ? 0 : 1);
      step("rr");
    end

    // ---- full stall after two words ----
    do_reset();
    bus.req_valid = 4'b1010;
    bus.req_data  = 32'h33221100;
    eg = '{0, 1, 1, 1, 1, 1, 1, 1, 3};
    ew = '{0, 1, 1, 0, 0, 0, 1, 1, 1};
    for (int c = 0; c < 9; c++) begin
      bus.fifo_full = (c >= 3 && c <= 5);
      #1;
      chk($sformatf("full%0d.gnt", c),   32'(gnt_id),        32'(eg[c]));
      chk($sformatf("full%0d.wr", c),    32'(bus.fifo_wr),   32'(ew[c]));
      chk($sformatf("full%0d.ready", c), 32'(bus.req_ready), ew[c] ? (32'd1 << eg[c]) : 32'd0);
      step("full");
    end
    bus.fifo_full = 1'b0;

    // ---- early release: requester 1 drops valid after one word ----
    do_reset();
    bus.req_data = 32'h33221100;
    eg = '{0, 1, 1, 3, 3, 3, 3, 3, 3};
    ew = '{0, 1, 0, 1, 1, 1, 1, 1, 1};
    for (int c = 0; c < 7; c++) begin
      bus.req_valid = (c < 2) ? 4'b1010 : 4'b1000;
      #1;
      chk($sformatf("early%0d.gnt", c), 32'(gnt_id),      32'(eg[c]));
      chk($sformatf("early%0d.wr", c),  32'(bus.fifo_wr), 32'(ew[c]));
      step("early");
    end

    // ---- asynchronous reset in the middle of a write cycle ----
    do_reset();
    bus.req_valid = 4'b1111;
    bus.req_data  = 32'h33221100;
    #1; step("ar");
    #1; step("ar");
    #1;
    chk("async.pre_wr", 32'(bus.fifo_wr), 1);
    #1;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("async.wr",    32'(bus.fifo_wr), 0);
    chk("async.ready", 32'(bus.req_ready), 0);
    chk("async.busy",  32'(busy), 0);
    chk("async.gnt",   32'(gnt_id), 0);
    bus.req_valid = 4'b1100;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1; step("ar_post");
    #1;
    chk("async.first_gnt", 32'(gnt_id), 2);
    chk("async.first_wr",  32'(bus.fifo_wr), 1);
    step("ar_post");

    // ---- requesters 0 and 2 continuously valid ----
    do_reset();
    bus.req_valid = 4'b0101;
    bus.req_data  = 32'h33221100;
    for (int c = 1; c <= 17; c++) begin
      #1;
      if (c > 1) begin
`ifdef FIFO_ARB_PRIO_EN
        e = 0;
`else
        e = (((c - 2) / 4) % 2 == 1) ? 2 : 0;
`endif
        chk($sformatf("pair%0d.gnt", c), 32'(gnt_id), 32'(e));
      end
      step("pair");
    end

    // ---- randomized traffic against the model ----
    do_reset();
    last_rdy = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!(bit_of(bus.req_valid, i) && !bit_of(last_rdy, i) && $urandom_range(0, 15) != 0)) begin
          bus.req_valid[i] = ($urandom_range(0, 2) != 0);
          bus.req_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        end
      end
      bus.fifo_full = ($urandom_range(0, 3) == 0);
      reset_n = ($urandom_range(0, 299) != 0);
      if (!reset_n) model_reset();
      #1;
      step("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the single write port of the team's synchronous FIFO (wr/Wdata/full) between NREQ producers.
- Each producer uses a valid/ready handshake.
- Grants are round-robin, and a granted producer keeps the port for a bounded burst of up to MAX_BURST words.
- Sits directly in front of the FIFO write side: fifo_wr/fifo_wdata connect to wr/Wdata, and fifo_full connects from full.

Parameters:
- WIDTH, 8: data word width; matches the FIFO WIDTH.
- NREQ, 4: number of requesters, >=2.
- MAX_BURST, 4: maximum words accepted per grant, >=1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  bit i: requester i has a word on its data slice.
- req_data  in  NREQ*WIDTH  slice [i*WIDTH +: WIDTH] is requester i's word.
- req_ready  out  NREQ  bit i: requester i's word is accepted this cycle.
- fifo_full  in  1  FIFO full flag.
- fifo_wr  out  1  FIFO write strobe.
- fifo_wdata  out  WIDTH  FIFO write data.
- gnt_id  out  IDW  index of the current grant holder; IDW = max(1,$clog2(NREQ)).
- busy  out  1  state is BURST.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, gnt_id=0, burst_cnt=0.
  - rr_ptr=NREQ-1, so the first search starts at requester 0.
  - All outputs low or zero while reset is held, including req_ready and fifo_wr.
  - Reset mid-burst aborts the burst with no further writes. A word presented in the reset cycle is not written.
- State machine (2 states):
  - IDLE: no grant; req_ready=0, fifo_wr=0. If any req_valid bit is set, select the winner = first set bit searching rr_ptr+1, rr_ptr+2, ... wrapping modulo NREQ. Register gnt_id=winner, burst_cnt=0, go to BURST. Arbitration costs one cycle; no transfer happens in IDLE.
  - BURST, with g=gnt_id:
    - xfer = req_valid[g] && !fifo_full.
    - req_ready[g]=!fifo_full; all other req_ready bits are 0.
    - fifo_wr=xfer, fifo_wdata=req_data slice g. Both are combinational, zero added latency. Outside a transfer, fifo_wdata=slice g with fifo_wr=0.
    - On xfer: burst_cnt++.
- Release from BURST occurs when either (xfer && burst_cnt==MAX_BURST-1) or !req_valid[g]. On release:
  - rr_ptr=g.
  - Re-arbitrate in the same cycle from g+1, wrapping. g is searched last and may win again only if it is the sole valid requester.
  - Winner found: stay in BURST with the new gnt_id and burst_cnt=0. This gives back-to-back grants with no bubble.
  - No winner: go to IDLE.
- Full handling:
  - fifo_full=1 stalls the transfer. Grant and burst_cnt hold.
  - Full alone never causes release.
  - fifo_wr is never asserted while fifo_full=1.
- Handshake rules:
  - A requester holding valid with ready=0 must keep its data stable; the arbiter does not check this.
  - A requester dropping valid while granted releases the grant, even if the FIFO is full.
- Widths: burst_cnt is max(1,$clog2(MAX_BURST)) bits. With MAX_BURST=1, every transfer releases.
- Invariants:
  - At most one req_ready bit is set at any time.
  - fifo_wr == |(req_valid & req_ready).

Optional Feature:
- Macro: FIFO_ARB_PRIO_EN.
- Defined: requester 0 is high priority. At every arbitration point (IDLE or release), req_valid[0]=1 wins regardless of rr_ptr. The burst limit still applies to requester 0, but it is re-granted immediately if still valid, so other requesters can starve; this is intended. rr_ptr still updates as above.
- Not defined: pure round-robin as described.
- The port list is identical in both builds.

Test Plan:
- Reset and single requester:
  - Stimulus: reset_n=0 then 1; only req_valid[2]=1, data 0xA0..0xA5 streamed, fifo_full=0.
  - Required response: IDLE for 1 cycle, then gnt_id=2. Four writes 0xA0..0xA3, release, immediate re-grant to 2 with no bubble, writes 0xA4, 0xA5.
- Round-robin fairness:
  - Stimulus: all 4 requesters continuously valid, MAX_BURST=4.
  - Required response: grant order 0,1,2,3,0. Each grant gives exactly 4 consecutive fifo_wr pulses. Gaps occur only after the initial IDLE cycle.
- Full stall:
  - Stimulus: fifo_full=1 for 3 cycles mid-burst, after 2 words written.
  - Required response: fifo_wr=0 and req_ready=0 during the stall. gnt_id and burst_cnt held. After full clears, exactly 2 more words, then release.
- Early release:
  - Stimulus: granted requester 1 drops req_valid after 1 word; requester 3 is valid.
  - Required response: gnt_id=3 on the next cycle, burst_cnt=0.
- Async reset mid-burst:
  - Stimulus: reset_n pulsed low between clock edges during a write cycle.
  - Required response: fifo_wr and req_ready drop immediately. After reset releases, the first grant goes to the lowest-index valid requester.
- FIFO_ARB_PRIO_EN:
  - Stimulus: requesters 0 and 2 continuously valid.
  - Required response: grant is always 0. Without the macro, grants alternate 0,2,0,2.
